chess_turn_timer: RTL

- Turn scheduler for the timed chess game. It owns the right-to-move token and gates the board layout controller with moveEnable.
- Runs one countdown clock per player and switches the active player on each committed move.
- Declares a loss on time.
- Sits between the push-button/switch inputs, the layout controller (source of moveDone) and the seven-segment time display.

---
 rtl/chess_turn_timer_pkg.sv | 20 ++
 rtl/chess_turn_timer_if.sv | 40 ++++
 rtl/chess_turn_timer_one_second_prescaler.sv | 36 +++
 rtl/chess_turn_timer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/chess_turn_timer_pkg.sv
// Shared encodings for the chess turn timer and the layout controller.
// Player constants match the layout controller's activePlayer encoding.
package chess_turn_timer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN_WHITE = 3'd1,
        RUN_BLACK = 3'd2,
        PAUSED    = 3'd3,
        TIMEOUT   = 3'd4
    } state_e;

    localparam logic WHITE_PLAYER = 1'b1;
    localparam logic BLACK_PLAYER = 1'b0;

    function automatic logic is_running(input state_e s);
        return (s == RUN_WHITE) || (s == RUN_BLACK);
    endfunction

endpackage

// File: rtl/chess_turn_timer_if.sv
// Control pulses in, turn/time status out, between the game
// inputs, the layout controller, the display and the turn timer.
interface chess_turn_timer_if #(
    parameter int TIME_WIDTH = 10
);
    logic                  startGame;
    logic                  pauseToggle;
    logic                  moveDone;
    logic                  activePlayer;
    logic                  moveEnable;
    logic [TIME_WIDTH-1:0] whiteSeconds;
    logic [TIME_WIDTH-1:0] blackSeconds;
    logic                  timeoutFlag;
    logic                  loser;

    modport master (
        output startGame,
        output pauseToggle,
        output moveDone,
        input  activePlayer,
        input  moveEnable,
        input  whiteSeconds,
        input  blackSeconds,
        input  timeoutFlag,
        input  loser
    );

    modport slave (
        input  startGame,
        input  pauseToggle,
        input  moveDone,
        output activePlayer,
        output moveEnable,
        output whiteSeconds,
        output blackSeconds,
        output timeoutFlag,
        output loser
    );

endinterface

// File: rtl/chess_turn_timer_one_second_prescaler.sv
// Divides the system clock down to a one-second tick.
// Tick fires on the wrap cycle, CLOCK_FREQUENCY cycles after a clear.
module one_second_prescaler #(
    parameter int CLOCK_FREQUENCY = 50000000
) (
    input  logic clock,
    input  logic resetApp,
    input  logic hold_i,
    input  logic clear_i,
    output logic tick_o
);
    localparam int CW = $clog2(CLOCK_FREQUENCY);
    localparam logic [CW-1:0] LAST = CW'(CLOCK_FREQUENCY - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = !hold_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetApp) begin
        if (!resetApp) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chess_turn_timer.sv
// Turn scheduler: owns the right-to-move token, runs both player
// clocks and declares a loss on time.
module chess_turn_timer #(
    parameter int CLOCK_FREQUENCY   = 50000000,
    parameter int INITIAL_SECONDS   = 300,
    parameter int INCREMENT_SECONDS = 0,
    parameter int TIME_WIDTH        = 10
) (
    input logic               clock,
    input logic               resetApp,
    chess_turn_timer_if.slave bus
);
    import chess_turn_timer_pkg::*;

    localparam logic [TIME_WIDTH-1:0] INIT = TIME_WIDTH'(INITIAL_SECONDS);
    localparam logic [TIME_WIDTH-1:0] ONE  = TIME_WIDTH'(1);

    state_e                state_q, state_d;
    state_e                saved_q, saved_d;
    logic [TIME_WIDTH-1:0] white_q, white_d;
    logic [TIME_WIDTH-1:0] black_q, black_d;
    logic                  player_q, player_d;
    logic                  loser_q, loser_d;
    logic                  enable_q, enable_d;
    logic                  timeout_q, timeout_d;

    logic                  run;
    logic                  tick;
    logic                  clear;
    logic [TIME_WIDTH-1:0] white_cr, black_cr;
    logic [TIME_WIDTH-1:0] active_secs;

    assign run = is_running(state_q);

    one_second_prescaler #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_prescaler (
        .clock   (clock),
        .resetApp(resetApp),
        .hold_i  (!run),
        .clear_i (clear),
        .tick_o  (tick)
    );

    // Mover's credit after a committed move, saturating at all-ones.
    if (INCREMENT_SECONDS == 0) begin : g_no_inc
        assign white_cr = white_q;
        assign black_cr = black_q;
    end else begin : g_inc
        localparam logic [31:0] MAXV = 32'((1 << TIME_WIDTH) - 1);
        logic [31:0] white_sum, black_sum;
        assign white_sum = 32'(white_q) + 32'(INCREMENT_SECONDS);
        assign black_sum = 32'(black_q) + 32'(INCREMENT_SECONDS);
        assign white_cr  = (white_sum > MAXV) ? '1
                                              : white_sum[TIME_WIDTH-1:0];
        assign black_cr  = (black_sum > MAXV) ? '1
                                              : black_sum[TIME_WIDTH-1:0];
    end

    assign active_secs = (state_q == RUN_WHITE) ? white_q : black_q;

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        white_d  = white_q;
        black_d  = black_q;
        player_d = player_q;
        loser_d  = loser_q;
        clear    = 1'b0;

        if (bus.startGame) begin
            state_d  = RUN_WHITE;
            white_d  = INIT;
            black_d  = INIT;
            player_d = WHITE_PLAYER;
            loser_d  = BLACK_PLAYER;
            clear    = 1'b1;
        end else begin
            unique case (state_q)
                RUN_WHITE, RUN_BLACK: begin
                    // A move beats a coincident tick; that tick is dropped.
                    if (bus.moveDone) begin
                        clear = 1'b1;
                        if (state_q == RUN_WHITE) begin
                            white_d  = white_cr;
                            player_d = BLACK_PLAYER;
                            state_d  = RUN_BLACK;
                        end else begin
                            black_d  = black_cr;
                            player_d = WHITE_PLAYER;
                            state_d  = RUN_WHITE;
                        end
                    end else if (tick) begin
                        if (active_secs <= ONE) begin
                            state_d = TIMEOUT;
                            loser_d = player_q;
                            if (state_q == RUN_WHITE) white_d = '0;
                            else                      black_d = '0;
                        end else if (state_q == RUN_WHITE) begin
                            white_d = white_q - ONE;
                        end else begin
                            black_d = black_q - ONE;
                        end
                    end
                    if (bus.pauseToggle && state_d != TIMEOUT) begin
                        saved_d = state_d;
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (bus.pauseToggle) state_d = saved_q;
                end
                default: ;
            endcase
        end

        enable_d  = is_running(state_d);
        timeout_d = (state_d == TIMEOUT);
    end

    always_ff @(posedge clock or negedge resetApp) begin
        if (!resetApp) begin
            state_q   <= IDLE;
            saved_q   <= RUN_WHITE;
            white_q   <= INIT;
            black_q   <= INIT;
            player_q  <= WHITE_PLAYER;
            loser_q   <= BLACK_PLAYER;
            enable_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            white_q   <= white_d;
            black_q   <= black_d;
            player_q  <= player_d;
            loser_q   <= loser_d;
            enable_q  <= enable_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.activePlayer = player_q;
    assign bus.moveEnable   = enable_q;
    assign bus.whiteSeconds = white_q;
    assign bus.blackSeconds = black_q;
    assign bus.timeoutFlag  = timeout_q;
    assign bus.loser        = loser_q;

endmodule
